// File: rtl/fetch_queue_if.sv
// Fetch-queue bus: redirect/halt control, instruction-memory port and decode handshake.
// master is the fetch_queue side, slave is the core/memory side.
interface fetch_queue_if #(
    parameter int unsigned N     = 32,
    parameter int unsigned DEPTH = 4
);
    logic                     redirect;
    logic [N-1:0]             redirect_pc;
    logic                     halt;
    logic [N-1:0]             imem_addr;
    logic [N-1:0]             imem_data;
    logic                     id_ready;
    logic                     id_valid;
    logic [N-1:0]             id_instr;
    logic [N-1:0]             id_pc;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        input  redirect, redirect_pc, halt, imem_data, id_ready,
        output imem_addr, id_valid, id_instr, id_pc, count
    );

    modport slave (
        output redirect, redirect_pc, halt, imem_data, id_ready,
        input  imem_addr, id_valid, id_instr, id_pc, count
    );
endinterface

// File: rtl/fetch_queue.sv
// Fetch stage: owns the PC, fetches one instruction per cycle into a DEPTH-entry
// {pc, instr} FIFO feeding decode; redirect flushes, halt freezes the PC.
module fetch_queue #(
    parameter int unsigned N        = 32,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned INC      = 4,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic                clock,
    input  logic                reset,
    fetch_queue_if.master       bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [N-1:0]  pc_q, pc_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [N-1:0] instr_mem_q [DEPTH];
    logic [N-1:0] pc_mem_q    [DEPTH];

    logic empty;
    logic full;
    logic pop;
    logic push;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign pop   = !empty && bus.id_ready && !bus.redirect;
    // A pop frees the slot the write pointer is aiming at, so full+pop may still push.
    assign push  = !bus.redirect && !bus.halt && (!full || pop);

    always_comb begin
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.redirect) begin
            pc_d     = bus.redirect_pc;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                pc_d     = pc_q + N'(INC);
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q     <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only visible once count covers it.
    always_ff @(posedge clock) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= bus.imem_data;
            pc_mem_q[wr_ptr_q]    <= pc_q;
        end
    end

    // Outputs depend only on flops, so there is no input-to-id_* path.
    assign bus.imem_addr = pc_q;
    assign bus.count     = count_q;
    assign bus.id_valid  = !empty;
    assign bus.id_instr  = empty ? '0 : instr_mem_q[rd_ptr_q];
    assign bus.id_pc     = empty ? '0 : pc_mem_q[rd_ptr_q];
endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue checked against a queue-based reference model.
module tb_fetch_queue;
    localparam int unsigned N     = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned INC   = 4;

    typedef struct packed {
        logic [N-1:0] pc;
        logic [N-1:0] instr;
    } entry_t;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    entry_t       model_q [$];
    logic [N-1:0] model_pc;

    fetch_queue_if #(.N(N), .DEPTH(DEPTH)) bus ();

    fetch_queue #(
        .N       (N),
        .DEPTH   (DEPTH),
        .INC     (INC),
        .RESET_PC('0)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    // Instruction memory: combinational, data = 0xA0 + address.
    assign bus.imem_data = 32'hA0 + bus.imem_addr;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        model_pc = '0;
    endtask

    // Applied at each rising edge using the inputs held during that cycle.
    task automatic model_edge(input logic rdy, input logic hlt, input logic rdr,
                              input logic [N-1:0] tgt);
        bit vld;
        bit pop;
        bit push;
        vld  = (model_q.size() != 0);
        pop  = vld && rdy && !rdr;
        push = !rdr && !hlt && ((model_q.size() < DEPTH) || pop);
        if (rdr) begin
            model_q.delete();
            model_pc = tgt;
        end else begin
            if (pop) void'(model_q.pop_front());
            if (push) begin
                model_q.push_back('{pc: model_pc, instr: 32'hA0 + model_pc});
                model_pc = model_pc + INC;
            end
        end
    endtask

    task automatic check_all(input string phase);
        entry_t head;
        head = (model_q.size() != 0) ? model_q[0] : '0;
        check_eq({phase, ".valid"}, N'(bus.id_valid), N'(model_q.size() != 0));
        check_eq({phase, ".pc"}, bus.id_pc, head.pc);
        check_eq({phase, ".instr"}, bus.id_instr, head.instr);
        check_eq({phase, ".count"}, N'(bus.count), N'(model_q.size()));
        check_eq({phase, ".addr"}, bus.imem_addr, model_pc);
    endtask

    task automatic step(input string phase, input logic rdy, input logic hlt, input logic rdr,
                        input logic [N-1:0] tgt);
        bus.id_ready    = rdy;
        bus.halt        = hlt;
        bus.redirect    = rdr;
        bus.redirect_pc = tgt;
        @(posedge clock);
        model_edge(rdy, hlt, rdr, tgt);
        @(negedge clock);
        check_all(phase);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        check_all("reset");
        reset = 1'b1;
    endtask

    initial begin
        logic [N-1:0] held_pc;
        total = 0;
        bad   = 0;
        bus.id_ready    = 1'b0;
        bus.halt        = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        do_reset();

        // Streaming with decode always ready.
        for (int i = 0; i < 3; i++) begin
            step("stream", 1'b1, 1'b0, 1'b0, '0);
            check_eq("stream.count_le1", N'(bus.count <= 1), 1);
        end

        // Fill to saturation from a clean start.
        do_reset();
        for (int i = 0; i < 6; i++) step("fill", 1'b0, 1'b0, 1'b0, '0);
        check_eq("full.count", N'(bus.count), 4);
        check_eq("full.addr", bus.imem_addr, 32'h10);

        // Pop and push together at full.
        step("fullpop", 1'b1, 1'b0, 1'b0, '0);
        check_eq("fullpop.count", N'(bus.count), 4);
        check_eq("fullpop.addr", bus.imem_addr, 32'h14);
        check_eq("fullpop.head", bus.id_pc, 32'h4);

        // Drain under halt, then queue three and redirect.
        for (int i = 0; i < 5; i++) step("drain", 1'b1, 1'b1, 1'b0, '0);
        for (int i = 0; i < 3; i++) step("q3", 1'b0, 1'b0, 1'b0, '0);
        check_eq("q3.count", N'(bus.count), 3);
        step("redir", 1'b1, 1'b0, 1'b1, 32'h200);
        check_eq("redir.count", N'(bus.count), 0);
        check_eq("redir.valid", N'(bus.id_valid), 0);
        check_eq("redir.addr", bus.imem_addr, 32'h200);
        step("redir1", 1'b0, 1'b0, 1'b0, '0);
        check_eq("redir1.pc", bus.id_pc, 32'h200);

        // Halt with two queued: both drain and PC stays put.
        step("q2", 1'b0, 1'b0, 1'b0, '0);
        held_pc = bus.imem_addr;
        step("halt", 1'b1, 1'b1, 1'b0, '0);
        step("halt", 1'b1, 1'b1, 1'b0, '0);
        check_eq("halt.count", N'(bus.count), 0);
        check_eq("halt.addr", bus.imem_addr, held_pc);
        step("resume", 1'b0, 1'b0, 1'b0, '0);
        check_eq("resume.pc", bus.id_pc, held_pc);

        // PC wraps from the top of the address space to zero.
        step("wrap0", 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step("wrap1", 1'b1, 1'b0, 1'b0, '0);
        check_eq("wrap.addr", bus.imem_addr, 32'h0);
        check_eq("wrap.head", bus.id_pc, 32'hFFFF_FFFC);

        // Randomized mix of stalls, halts and redirects.
        for (int i = 0; i < 3000; i++) begin
            step("rand",
                 ($urandom_range(99) < 60),
                 ($urandom_range(99) < 15),
                 ($urandom_range(99) < 5),
                 $urandom());
        end

        // Asynchronous reset mid-cycle with entries queued.
        for (int i = 0; i < 3; i++) step("prefill", 1'b0, 1'b0, 1'b0, '0);
        check_eq("prefill.valid", N'(bus.id_valid), 1);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_all("async");
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) step("post", 1'b1, 1'b0, 1'b0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
